// File: rtl/adder_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : adder_seq_ctrl
//  Purpose  : Adds two N*WORDS-bit operands by stepping one external N-bit
//             combinational adder through the operands one chunk per cycle,
//             LSB chunk first, and chaining the chunk carry between cycles.
//  Ports    : clk, rst                  - clock, synchronous active-high reset
//             start_valid/start_ready   - operand handshake (A_in, B_in, Cin_in)
//             add_A/add_B/add_Cin       - chunk operands driven to the adder
//             add_Sum/add_Cout          - chunk result returned by the adder
//             Sum_out/Cout_out          - wide result
//             done_valid/done_ready     - result handshake
//             busy                      - high while chunks are being added
//  Revision : 1.0 - initial release
// ============================================================================
module adder_seq_ctrl #(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [N*WORDS-1:0] A_in,
    input  logic [N*WORDS-1:0] B_in,
    input  logic               Cin_in,
    output logic [N-1:0]       add_A,
    output logic [N-1:0]       add_B,
    output logic               add_Cin,
    input  logic [N-1:0]       add_Sum,
    input  logic               add_Cout,
    output logic [N*WORDS-1:0] Sum_out,
    output logic               Cout_out,
    output logic               done_valid,
    input  logic               done_ready,
    output logic               busy
);

    localparam int c_width = N * WORDS;
    // A one-chunk operation still needs a 1-bit index register.
    localparam int c_idx_w = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(WORDS - 1);
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_idx_w-1:0] r_idx;
    logic               r_carry;
    logic [c_width-1:0] r_a;
    logic [c_width-1:0] r_b;
    logic [c_width-1:0] r_sum;
    logic               r_cout;
    logic               w_last;
    logic [31:0]        w_off;

    assign w_last = (r_idx == c_last_idx);
    // Bit offset of the chunk currently on the adder.
    assign w_off  = 32'(r_idx) * 32'(N);

    assign start_ready = (r_state == c_idle);
    assign busy        = (r_state == c_run);
    assign done_valid  = (r_state == c_done);
    assign Sum_out     = r_sum;
    assign Cout_out    = r_cout;

    // Adder inputs are forced to zero outside RUN so the shared adder sees
    // quiet operands while this block is idle or holding a result.
    always_comb begin
        add_A   = '0;
        add_B   = '0;
        add_Cin = 1'b0;
        if (r_state == c_run) begin
            add_A   = r_a[w_off +: N];
            add_B   = r_b[w_off +: N];
            add_Cin = r_carry;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (start_valid) w_state_nxt = c_run;
            c_run:   if (w_last)      w_state_nxt = c_done;
            c_done:  if (done_ready)  w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (start_valid) begin
                        r_a     <= A_in;
                        r_b     <= B_in;
                        r_carry <= Cin_in;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                    end
                end
                c_run: begin
                    r_sum[w_off +: N] <= add_Sum;
                    r_carry           <= add_Cout;
                    if (w_last) begin
                        // Final carry becomes the wide carry-out; it is not
                        // carried into the next operation (reloaded on accept).
                        r_cout <= add_Cout;
                        r_idx  <= '0;
                    end else begin
                        r_idx <= r_idx + c_idx_one;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_seq_ctrl
//  Purpose  : Self-checking bench for adder_seq_ctrl. Two instances are used:
//             N=4/WORDS=4 and N=8/WORDS=1, each attached to an ideal
//             combinational adder. Expected results are queued on accept and
//             compared by monitor processes when a result is taken.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adder_seq_ctrl;

    localparam int N1 = 4;
    localparam int WD1 = 4;
    localparam int W1 = N1 * WD1;
    localparam int N2 = 8;
    localparam int WD2 = 1;
    localparam int W2 = N2 * WD2;

    logic clk = 1'b0;
    logic rst;

    // Instance 1 signals
    logic          start_valid, start_ready, Cin_in, add_Cin, add_Cout;
    logic [W1-1:0] A_in, B_in, Sum_out;
    logic [N1-1:0] add_A, add_B, add_Sum;
    logic          Cout_out, done_valid, done_ready, busy;

    // Instance 2 signals
    logic          start_valid2, start_ready2, Cin_in2, add_Cin2, add_Cout2;
    logic [W2-1:0] A_in2, B_in2, Sum_out2;
    logic [N2-1:0] add_A2, add_B2, add_Sum2;
    logic          Cout_out2, done_valid2, done_ready2, busy2;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    bit stall_en = 1'b0;

    logic [W1:0] q1[$];
    logic [W2:0] q2[$];
    logic [W1:0] e1;
    logic [W2:0] e2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Ideal external adders
    assign {add_Cout, add_Sum}   = {1'b0, add_A} + {1'b0, add_B} + {{N1{1'b0}}, add_Cin};
    assign {add_Cout2, add_Sum2} = {1'b0, add_A2} + {1'b0, add_B2} + {{N2{1'b0}}, add_Cin2};

    adder_seq_ctrl #(.N(N1), .WORDS(WD1)) u_dut1 (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready),
        .A_in(A_in), .B_in(B_in), .Cin_in(Cin_in),
        .add_A(add_A), .add_B(add_B), .add_Cin(add_Cin),
        .add_Sum(add_Sum), .add_Cout(add_Cout),
        .Sum_out(Sum_out), .Cout_out(Cout_out),
        .done_valid(done_valid), .done_ready(done_ready), .busy(busy)
    );

    adder_seq_ctrl #(.N(N2), .WORDS(WD2)) u_dut2 (
        .clk(clk), .rst(rst),
        .start_valid(start_valid2), .start_ready(start_ready2),
        .A_in(A_in2), .B_in(B_in2), .Cin_in(Cin_in2),
        .add_A(add_A2), .add_B(add_B2), .add_Cin(add_Cin2),
        .add_Sum(add_Sum2), .add_Cout(add_Cout2),
        .Sum_out(Sum_out2), .Cout_out(Cout_out2),
        .done_valid(done_valid2), .done_ready(done_ready2), .busy(busy2)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Carry into chunk i = carry out of the low i chunks of a+b+cin.
    function automatic logic carry_in(input logic [W1-1:0] a, input logic [W1-1:0] b,
                                      input logic cin, input int i);
        logic [W1:0] m;
        logic [W1:0] s;
        m = (17'd1 << (N1 * i)) - 17'd1;
        s = ({1'b0, a} & m) + ({1'b0, b} & m) + {16'd0, cin};
        return s[N1 * i];
    endfunction

    // Random result-side stalls
    always @(posedge clk) begin
        #1;
        if (stall_en) begin
            done_ready  = ($urandom_range(0, 3) != 0);
            done_ready2 = ($urandom_range(0, 3) != 0);
        end
    end

    // Scoreboard monitors: compare when a result is being taken
    always @(negedge clk) begin
        if (!rst && done_valid) begin
            if (q1.size() == 0) chk("spurious_done1", 1, 0);
            else if (done_ready) begin
                e1 = q1.pop_front();
                chk("result1", {Cout_out, Sum_out}, e1);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done_valid2) begin
            if (q2.size() == 0) chk("spurious_done2", 1, 0);
            else if (done_ready2) begin
                e2 = q2.pop_front();
                chk("result2", {Cout_out2, Sum_out2}, e2);
            end
        end
    end

    task automatic do_op1(input logic [W1-1:0] a, input logic [W1-1:0] b, input logic cin);
        int n;
        A_in = a; B_in = b; Cin_in = cin; start_valid = 1'b1;
        n = 0;
        while (!start_ready && n < 100) begin tick(); n++; end
        chk("accept_wait1", start_ready, 1);
        if (start_ready) q1.push_back({1'b0, a} + {1'b0, b} + {16'd0, cin});
        tick();
        start_valid = 1'b0;
    endtask

    task automatic do_op2(input logic [W2-1:0] a, input logic [W2-1:0] b, input logic cin);
        int n;
        A_in2 = a; B_in2 = b; Cin_in2 = cin; start_valid2 = 1'b1;
        n = 0;
        while (!start_ready2 && n < 100) begin tick(); n++; end
        chk("accept_wait2", start_ready2, 1);
        if (start_ready2) q2.push_back({1'b0, a} + {1'b0, b} + {8'd0, cin});
        tick();
        start_valid2 = 1'b0;
        // Single chunk: one RUN cycle with the whole operand on the adder.
        chk("w1_busy", busy2, 1);
        chk("w1_add_A", add_A2, a);
        chk("w1_add_B", add_B2, b);
        chk("w1_add_Cin", add_Cin2, cin);
        tick();
        chk("w1_done", done_valid2, 1);
    endtask

    // Directed op on instance 1 with per-cycle adder-side checks; done_ready=1.
    task automatic run_directed(input logic [W1-1:0] a, input logic [W1-1:0] b, input logic cin);
        logic [W1:0] exp;
        exp = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        do_op1(a, b, cin);
        for (int i = 0; i < WD1; i++) begin
            chk("dir_add_A", add_A, (a >> (N1 * i)) & 16'hF);
            chk("dir_add_B", add_B, (b >> (N1 * i)) & 16'hF);
            chk("dir_add_Cin", add_Cin, carry_in(a, b, cin, i));
            chk("dir_busy", busy, 1);
            chk("dir_not_done", done_valid, 0);
            tick();
        end
        chk("dir_done_valid", done_valid, 1);
        chk("dir_sum", {Cout_out, Sum_out}, exp);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W1:0]   hold;
        logic [W1-1:0] a, b;
        logic          cin;
        int n, bcnt, last;

        rst = 1'b1;
        start_valid = 0; A_in = 0; B_in = 0; Cin_in = 0; done_ready = 1;
        start_valid2 = 0; A_in2 = 0; B_in2 = 0; Cin_in2 = 0; done_ready2 = 1;
        tick(); tick();
        chk("rst_start_ready", start_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_sum", {Cout_out, Sum_out}, 0);
        chk("rst_add", {add_A, add_B, add_Cin}, 0);
        chk("rst_start_ready2", start_ready2, 1);
        chk("rst_sum2", {Cout_out2, Sum_out2}, 0);
        rst = 1'b0;
        tick();

        // Directed vectors
        run_directed(16'h1234, 16'h1111, 1'b0);
        run_directed(16'hFFFF, 16'h0001, 1'b0);
        run_directed(16'hFFFF, 16'hFFFF, 1'b1);

        // Backpressure in DONE while start_valid pulses
        done_ready = 1'b0;
        do_op1(16'hABCD, 16'h1357, 1'b1);
        repeat (WD1) tick();
        chk("bp_done_valid", done_valid, 1);
        hold = {Cout_out, Sum_out};
        chk("bp_result", hold, 17'h0ABCD + 17'h01357 + 17'd1);
        for (int k = 0; k < 5; k++) begin
            start_valid = ((k % 2) == 0);
            A_in = 16'($urandom);
            tick();
            chk("bp_hold_valid", done_valid, 1);
            chk("bp_start_ready", start_ready, 0);
            chk("bp_hold_sum", {Cout_out, Sum_out}, hold);
            chk("bp_add_quiet", {add_A, add_Cin}, 0);
        end
        start_valid = 1'b0;
        done_ready = 1'b1;
        tick();
        chk("bp_idle_ready", start_ready, 1);
        chk("bp_idle_valid", done_valid, 0);
        tick();
        chk("bp_no_accept", busy, 0);
        chk("bp_retain_sum", {Cout_out, Sum_out}, hold);

        // Reset after two RUN cycles
        do_op1(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        tick(); tick();
        rst = 1'b1;
        q1.delete();
        tick();
        rst = 1'b0;
        chk("mid_rst_ready", start_ready, 1);
        chk("mid_rst_valid", done_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sum", {Cout_out, Sum_out}, 0);
        run_directed(16'h00FF, 16'h0001, 1'b0);

        // Back-to-back with both handshakes held high
        start_valid = 1'b1;
        done_ready = 1'b1;
        last = 0;
        bcnt = 0;
        for (int k = 0; k < 6; k++) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom_range(0, 1));
            A_in = a; B_in = b; Cin_in = cin;
            n = 0;
            while (!start_ready && n < 20) begin
                if (busy) bcnt++;
                tick();
                n++;
            end
            if (k > 0) begin
                chk("b2b_busy_cycles", bcnt, WD1);
                chk("b2b_period", cyc - last, WD1 + 2);
            end
            chk("b2b_ready", start_ready, 1);
            last = cyc;
            q1.push_back({1'b0, a} + {1'b0, b} + {16'd0, cin});
            bcnt = 0;
            tick();
        end
        start_valid = 1'b0;
        n = 0;
        while (!start_ready && n < 20) begin tick(); n++; end

        // Random operations with result stalls, instance 1
        stall_en = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            do_op1(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end
        stall_en = 1'b0;
        tick();
        done_ready = 1'b1;
        n = 0;
        while (q1.size() != 0 && n < 50) begin tick(); n++; end
        chk("drain1", q1.size(), 0);

        // Random operations with result stalls, instance 2 (WORDS=1, N=8)
        stall_en = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            do_op2(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        stall_en = 1'b0;
        tick();
        done_ready2 = 1'b1;
        n = 0;
        while (q2.size() != 0 && n < 50) begin tick(); n++; end
        chk("drain2", q2.size(), 0);

        tick(); tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
- Sequencer that adds wide operands (N*WORDS bits) by driving one external N-bit combinational adder one chunk per cycle, LSB chunk first.
- Sits on both sides of the adder. It feeds A, B and Cin into the adder. It consumes Sum and Cout and feeds Cout back as the next chunk's carry-in.
- Uses valid/ready handshakes on the operand side and the result side. This allows area-cheap wide addition on the datapath without instantiating a WORDS*N-bit adder.

Parameters:
- N, 4, chunk width. Must equal the N of the attached adder; N >= 1.
- WORDS, 4, number of chunks per operation; WORDS >= 1; total operand width W = N*WORDS.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- start_valid  input  1  operand request valid.
- start_ready  output  1  block can accept operands.
- A_in  input  W  operand A.
- B_in  input  W  operand B.
- Cin_in  input  1  carry-in for the LSB chunk.
- add_A  output  N  chunk of A to the adder.
- add_B  output  N  chunk of B to the adder.
- add_Cin  output  1  carry to the adder.
- add_Sum  input  N  adder sum, combinational from add_A/add_B/add_Cin.
- add_Cout  input  1  adder carry-out.
- Sum_out  output  W  wide sum result.
- Cout_out  output  1  wide carry-out.
- done_valid  output  1  result valid.
- done_ready  input  1  consumer takes result.
- busy  output  1  high in RUN.

Behaviour:
- Reset (rst=1 at edge):
  - state <= IDLE; idx <= 0; carry reg <= 0.
  - A/B operand regs <= 0; Sum_out <= 0; Cout_out <= 0.
  - rst has priority over all other events, including mid-RUN and in DONE. A partial result is discarded; no done_valid is produced for the aborted operation.
- States: IDLE, RUN, DONE (binary-encoded, 2 bits).
- Combinational outputs:
  - start_ready = (state==IDLE).
  - busy = (state==RUN).
  - done_valid = (state==DONE).
- IDLE:
  - On start_valid & start_ready: latch A_in, B_in; carry <= Cin_in; idx <= 0; Sum_out <= 0; Cout_out <= 0; state <= RUN.
  - Otherwise hold all state.
- RUN:
  - add_A = A_reg[idx*N +: N]; add_B = B_reg[idx*N +: N]; add_Cin = carry.
  - Each edge: Sum_out[idx*N +: N] <= add_Sum; carry <= add_Cout.
  - If idx == WORDS-1: Cout_out <= add_Cout; idx <= 0; state <= DONE.
  - Otherwise idx <= idx+1.
  - start_valid is ignored in RUN.
- Outside RUN: add_A = 0, add_B = 0, add_Cin = 0.
- DONE:
  - Sum_out and Cout_out are stable and equal to {Cout,Sum} = A+B+Cin, modulo 2^(W+1).
  - Hold until done_ready=1 at an edge, then state <= IDLE.
  - Sum_out/Cout_out retain their value after leaving DONE until the next accept.
- Latency:
  - Accept edge at cycle 0; done_valid rises after the WORDS-th following edge, i.e. WORDS cycles in RUN.
  - Minimum operation period is WORDS+2 cycles (accept, WORDS RUN cycles, DONE handshake).
  - The block returns to IDLE for at least one cycle between operations; there is no same-cycle DONE→RUN.
- WORDS=1: exactly one RUN cycle; idx counter width is max(1, clog2(WORDS)).
- The carry chain wraps only within an operation. The final add_Cout goes to Cout_out and is never reused for the next operation.
- No assertion of done_valid without a prior accepted start.

Test Plan:
- N=4, WORDS=4: A_in=0x1234, B_in=0x1111, Cin_in=0:
  - add_A sequence 4,3,2,1 on consecutive RUN cycles.
  - Then done_valid=1, Sum_out=0x2345, Cout_out=0, exactly 4 cycles after the accept edge.
- Full carry ripple:
  - A_in=0xFFFF, B_in=0x0001, Cin_in=0 → add_Cin sequence 0,1,1,1; Sum_out=0x0000, Cout_out=1.
  - A_in=0xFFFF, B_in=0xFFFF, Cin_in=1 → Sum_out=0xFFFF, Cout_out=1.
- Backpressure: hold done_ready=0 for 5 cycles in DONE while pulsing start_valid.
  - done_valid stays 1; Sum_out/Cout_out unchanged; start_ready=0; the start is not accepted.
  - done_ready=1 → IDLE next cycle.
- Reset mid-operation: assert rst for 1 cycle after 2 RUN cycles.
  - Next cycle: state IDLE, start_ready=1, Sum_out=0, Cout_out=0, done_valid=0.
  - A following A_in=0x00FF, B_in=0x0001 yields Sum_out=0x0100, Cout_out=0.
- Back-to-back: start_valid held high, done_ready held high.
  - Operations are accepted every 6 cycles (WORDS+2); each result is correct.
  - busy is high exactly 4 cycles per operation.
- Random: 1000 random A_in, B_in, Cin_in with random done_ready stalls, checked against a W+1-bit reference sum. Repeat with WORDS=1 and N=8.
